// File: rtl/taxi_rst_seq.sv
// taxi_rst_seq: lock-qualified reset sequencer.
//
// Each lock_in bit passes through its own synchronizer. The AND of the
// synchronized bits (lock_ok) must stay high for HOLD_CYCLES cycles. After
// that, the rst_out bits are released one at a time, bit 0 first, with
// STAGE_DELAY cycles between releases. ready rises STAGE_DELAY cycles after
// the last bit is released.
//
// Losing lock after qualification reasserts every reset on the next cycle.
// It also pulses lock_loss and bumps a saturating counter. force_rst also
// reasserts every reset, but it does not count as a lock loss.
//
// Ports:
//   clk            sole clock
//   rst_n          asynchronous active-low reset
//   lock_in        [N_LOCK] asynchronous lock indicators, active high
//   force_rst      synchronous request to reassert all resets
//   rst_out        [N_RST] sequenced resets, active high
//   ready          all resets released and sequence complete
//   lock_loss      one-cycle pulse on lock loss after qualification
//   lock_loss_cnt  [CNT_W] saturating count of lock-loss events
//   state_dbg      [2] current FSM state (0 HOLD, 1 QUAL, 2 RELEASE, 3 RUN)
//
// Handshake note: there is no valid/ready traffic here. ready is a level
// status, not a handshake.
module taxi_rst_seq #(
  parameter int N_LOCK      = 1,
  parameter int N_RST       = 1,
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LOCK-1:0] lock_in,
  input  logic              force_rst,
  output logic [N_RST-1:0]  rst_out,
  output logic              ready,
  output logic              lock_loss,
  output logic [CNT_W-1:0]  lock_loss_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int QUAL_W   = $clog2(HOLD_CYCLES + 1);
  localparam int REL_W    = $clog2(N_RST * STAGE_DELAY + 1);
  localparam int REL_LAST = N_RST * STAGE_DELAY - 1;

  localparam logic [QUAL_W-1:0] QUAL_END = QUAL_W'(HOLD_CYCLES);
  localparam logic [REL_W-1:0]  REL_END  = REL_W'(REL_LAST);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q [N_LOCK];
  logic [N_LOCK-1:0]      sync_last;
  logic                   lock_ok;
  logic [QUAL_W-1:0]      qual_cnt;
  logic [REL_W-1:0]       rel_cnt;
  logic                   in_service;

  // Lock synchronizers: one shift register per lock bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LOCK; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_LOCK; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], lock_in[i]};
    end
  end

  always_comb begin
    sync_last = '0;
    for (int i = 0; i < N_LOCK; i++) sync_last[i] = sync_q[i][SYNC_STAGES-1];
  end

  assign lock_ok    = &sync_last;
  assign in_service = (state == ST_RELEASE) || (state == ST_RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HOLD;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:    if (lock_ok && !force_rst) state_nxt = ST_QUAL;
      ST_QUAL:    if (!lock_ok || force_rst) state_nxt = ST_HOLD;
                  else if (qual_cnt == QUAL_END) state_nxt = ST_RELEASE;
      ST_RELEASE: if (!lock_ok || force_rst) state_nxt = ST_HOLD;
                  else if (rel_cnt == REL_END) state_nxt = ST_RUN;
      ST_RUN:     if (!lock_ok || force_rst) state_nxt = ST_HOLD;
      default:    state_nxt = ST_HOLD;
    endcase
  end

  // A counter only advances while its state persists, so it can never pass
  // its terminal value. It reads zero on entry to its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      qual_cnt <= (state == ST_QUAL && state_nxt == ST_QUAL) ? qual_cnt + 1'b1 : '0;
      rel_cnt  <= (state == ST_RELEASE && state_nxt == ST_RELEASE) ? rel_cnt + 1'b1 : '0;
    end
  end

  // A lock drop in service always counts as a loss, even when force_rst is
  // asserted in the same cycle. The FSM leaves service on the same edge, so
  // the pulse lasts a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      lock_loss <= in_service && !lock_ok;
      if (in_service && !lock_ok && (lock_loss_cnt != {CNT_W{1'b1}}))
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

  // Output logic. Bit k is released once rel_cnt reaches k*STAGE_DELAY.
  // Releasing on entry to RELEASE gives bit 0 its zero offset.
  always_comb begin
    rst_out = '1;
    for (int k = 0; k < N_RST; k++)
      if (state == ST_RUN || (state == ST_RELEASE && int'(rel_cnt) >= k * STAGE_DELAY))
        rst_out[k] = 1'b0;
  end

  assign ready     = (state == ST_RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_taxi_rst_seq.sv
// Directed bench for taxi_rst_seq (N_LOCK=2, N_RST=3, SYNC_STAGES=3,
// HOLD_CYCLES=16, STAGE_DELAY=8). A second instance with CNT_W=2 shares all
// inputs so that counter saturation can be observed.
// Inputs are driven and outputs sampled on the falling clock edge. Edge 0
// is the first rising edge that samples a newly driven input value.
module tb_taxi_rst_seq;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n;
  logic [1:0] lock_in;
  logic       force_rst;

  logic [2:0]  rst_out;
  logic        ready;
  logic        lock_loss;
  logic [15:0] lock_loss_cnt;
  logic [1:0]  state_dbg;

  logic [2:0]  rst_out2;
  logic        ready2;
  logic        lock_loss2;
  logic [1:0]  lock_loss_cnt2;
  logic [1:0]  state_dbg2;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  initial forever #5 if (clk_en) clk = ~clk;

  taxi_rst_seq #(.N_LOCK(2), .N_RST(3), .SYNC_STAGES(3), .HOLD_CYCLES(16),
                 .STAGE_DELAY(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .force_rst(force_rst),
    .rst_out(rst_out), .ready(ready), .lock_loss(lock_loss),
    .lock_loss_cnt(lock_loss_cnt), .state_dbg(state_dbg)
  );

  taxi_rst_seq #(.N_LOCK(2), .N_RST(3), .SYNC_STAGES(3), .HOLD_CYCLES(16),
                 .STAGE_DELAY(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .force_rst(force_rst),
    .rst_out(rst_out2), .ready(ready2), .lock_loss(lock_loss2),
    .lock_loss_cnt(lock_loss_cnt2), .state_dbg(state_dbg2)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    lock_in = 2'b00;
    force_rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Watches for up to 100 edges. It records the edge at which each reset bit
  // falls and the edge at which ready rises. It also counts lock_loss pulses.
  task automatic run_seq(output int e0, output int e1, output int e2,
                         output int er, output int ll);
    e0 = -1; e1 = -1; e2 = -1; er = -1; ll = 0;
    for (int e = 0; e < 100; e++) begin
      @(negedge clk);
      if (lock_loss) ll++;
      if (e0 < 0 && !rst_out[0]) e0 = e;
      if (e1 < 0 && !rst_out[1]) e1 = e;
      if (e2 < 0 && !rst_out[2]) e2 = e;
      if (ready) begin
        er = e;
        break;
      end
    end
  endtask

  task automatic seq_check(input string pfx, input int x0, input int x1,
                           input int x2, input int xr);
    int e0, e1, e2, er, ll;
    run_seq(e0, e1, e2, er, ll);
    check({pfx, "_rst0_edge"}, 32'(e0), 32'(x0));
    check({pfx, "_rst1_edge"}, 32'(e1), 32'(x1));
    check({pfx, "_rst2_edge"}, 32'(e2), 32'(x2));
    check({pfx, "_ready_edge"}, 32'(er), 32'(xr));
    check({pfx, "_no_loss"}, 32'(ll), 32'd0);
  endtask

  initial begin
    int ll_acc;
    int e0, e1, e2, er, ll;
    logic [31:0] exp_sat_q[$];

    exp_sat_q = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};

    // Reset state.
    do_reset();
    check("rst_rst_out", 32'(rst_out), 32'd7);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_lock_loss", 32'(lock_loss), 32'd0);
    check("rst_cnt", 32'(lock_loss_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Boot with the locks already high.
    rst_n = 1'b1;
    lock_in = 2'b11;
    seq_check("boot", 20, 28, 36, 44);
    check("boot_cnt", 32'(lock_loss_cnt), 32'd0);

    // A lock glitch during qualification restarts qualification silently.
    do_reset();
    rst_n = 1'b1;
    lock_in = 2'b11;
    repeat (6) @(negedge clk);
    check("qual_state", 32'(state_dbg), 32'd1);
    lock_in = 2'b01;
    ll_acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (lock_loss) ll_acc++;
    end
    check("glitch_rst_held", 32'(rst_out), 32'd7);
    lock_in = 2'b11;
    seq_check("glitch", 20, 28, 36, 44);
    check("glitch_ll", 32'(ll_acc), 32'd0);
    check("glitch_cnt", 32'(lock_loss_cnt), 32'd0);

    // Lock loss in RUN.
    lock_in = 2'b10;
    repeat (3) @(negedge clk);
    check("loss_pre_rst", 32'(rst_out), 32'd0);
    check("loss_pre_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("loss_rst", 32'(rst_out), 32'd7);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_pulse", 32'(lock_loss), 32'd1);
    check("loss_cnt", 32'(lock_loss_cnt), 32'd1);
    check("loss_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    check("loss_pulse_end", 32'(lock_loss), 32'd0);
    lock_in = 2'b11;
    seq_check("relock", 20, 28, 36, 44);

    // force_rst in RUN, held for 3 cycles.
    force_rst = 1'b1;
    @(negedge clk);
    check("force_rst_out", 32'(rst_out), 32'd7);
    check("force_ready", 32'(ready), 32'd0);
    check("force_no_pulse", 32'(lock_loss), 32'd0);
    check("force_cnt", 32'(lock_loss_cnt), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("force_hold_state", 32'(state_dbg), 32'd0);
    end
    force_rst = 1'b0;
    seq_check("force", 17, 25, 33, 41);
    check("force_cnt_after", 32'(lock_loss_cnt), 32'd1);

    // Five losses, each while in RUN. The last one coincides with force_rst.
    do_reset();
    rst_n = 1'b1;
    lock_in = 2'b11;
    seq_check("boot2", 20, 28, 36, 44);
    for (int i = 0; i < 5; i++) begin
      lock_in = 2'b00;
      repeat (3) @(negedge clk);
      if (i == 4) force_rst = 1'b1;
      @(negedge clk);
      check("sat_pulse", 32'(lock_loss), 32'd1);
      check("sat_rst", 32'(rst_out), 32'd7);
      check("sat_cnt16", 32'(lock_loss_cnt), 32'(i + 1));
      check("sat_cnt2", 32'(lock_loss_cnt2), exp_sat_q.pop_front());
      force_rst = 1'b0;
      lock_in = 2'b11;
      run_seq(e0, e1, e2, er, ll);
      check("sat_relock_rst0", 32'(e0), 32'd20);
      check("sat_relock_ready", 32'(er), 32'd44);
    end

    // Asynchronous reset between releases of bits 1 and 2, clock stopped.
    do_reset();
    rst_n = 1'b1;
    lock_in = 2'b11;
    repeat (31) @(negedge clk);
    check("abort_pre_rst", 32'(rst_out), 32'd4);
    clk_en = 1'b0;
    #12;
    rst_n = 1'b0;
    #1;
    check("abort_rst_out", 32'(rst_out), 32'd7);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_pulse", 32'(lock_loss), 32'd0);
    check("abort_cnt", 32'(lock_loss_cnt), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    #10;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seq_check("restart", 20, 28, 36, 44);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/taxi_rst_seq.md
TAXI_RST_SEQ -- requirements
Module: taxi_rst_seq

Interface
REQ-001 Parameter N_LOCK, default 1: number of PLL/MMCM lock inputs qualified together (1..8).
REQ-002 Parameter N_RST, default 1: number of sequenced reset outputs (1..8).
REQ-003 Parameter SYNC_STAGES, default 3: synchronizer flops per lock input (2..5).
REQ-004 Parameter HOLD_CYCLES, default 16: cycles all locks must stay high before release (>=1).
REQ-005 Parameter STAGE_DELAY, default 8: cycles between successive reset releases (>=1).
REQ-006 Parameter CNT_W, default 16: lock-loss counter width (>=1).
REQ-007 clk  input  1  sole clock; all logic in this domain.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 lock_in  input  N_LOCK  asynchronous lock indicators, active high.
REQ-010 force_rst  input  1  synchronous request to reassert all resets, active high.
REQ-011 rst_out  output  N_RST  sequenced resets, active high, bit 0 released first.
REQ-012 ready  output  1  high only when all rst_out released and sequence complete.
REQ-013 lock_loss  output  1  single-cycle pulse on lock loss after qualification.
REQ-014 lock_loss_cnt  output  CNT_W  saturating count of lock-loss events.

Function
REQ-015 Each lock_in bit SHALL pass through its own SYNC_STAGES-flop synchronizer; lock_ok is the AND of all synchronized bits.
REQ-016 FSM states SHALL be HOLD, QUAL, RELEASE, RUN.
REQ-017 HOLD: all rst_out high, ready low, qualification counter cleared; go to QUAL when lock_ok=1 and force_rst=0.
REQ-018 QUAL: counter increments each cycle; lock_ok=0 or force_rst=1 returns to HOLD with no lock_loss pulse and no count change; after HOLD_CYCLES cycles go to RELEASE.
REQ-019 RELEASE: rst_out[0] deasserts on entry; rst_out[k] deasserts exactly STAGE_DELAY cycles after rst_out[k-1]; released bits stay low.
REQ-020 Enter RUN and assert ready exactly STAGE_DELAY cycles after rst_out[N_RST-1] deasserts; N_RST=1 uses the same rule.
REQ-021 Latency: rst_out[0] SHALL fall exactly SYNC_STAGES+HOLD_CYCLES+1 cycles after the first clk edge sampling all lock_in high (stable, force_rst low).
REQ-022 lock_ok=0 in RELEASE or RUN: next cycle all rst_out high, ready low, lock_loss high one cycle, lock_loss_cnt+1, state HOLD.
REQ-023 lock_loss_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 force_rst=1 in RELEASE or RUN: next cycle all rst_out high, ready low, state HOLD; no lock_loss pulse, no count change.
REQ-025 Simultaneous lock_ok=0 and force_rst=1 in RELEASE/RUN SHALL be treated as lock loss (pulse and count).
REQ-026 While force_rst=1 the FSM SHALL remain in HOLD regardless of lock_ok.

Reset
REQ-027 rst_n low SHALL, without a clock edge, force rst_out all ones, ready 0, lock_loss 0, lock_loss_cnt 0, synchronizers 0, state HOLD.
REQ-028 rst_n assertion mid-sequence SHALL abort immediately; on deassertion the full sequence restarts from HOLD.

Verification (N_LOCK=2, N_RST=3, SYNC_STAGES=3, HOLD_CYCLES=16, STAGE_DELAY=8, CNT_W=16 unless stated)
REQ-029 Locks high from reset release (edge 0) -> rst_out[0] falls at edge 20, [1] at 28, [2] at 36, ready rises at 44, lock_loss_cnt 0.
REQ-030 lock_in[1] low 4 cycles during QUAL -> no rst_out released, lock_loss never pulses, count 0; release occurs 20 cycles after lock_in[1] returns high.
REQ-031 In RUN, drop lock_in[0] -> within 4 cycles rst_out=3'b111, ready 0, one-cycle lock_loss, count 1; relock -> full sequence repeats with identical spacing.
REQ-032 force_rst pulse after rst_out[0] released -> next cycle rst_out=3'b111, count unchanged, no lock_loss; sequence restarts after force_rst drops.
REQ-033 CNT_W=2, five lock losses in RUN -> lock_loss_cnt reads 1,2,3,3,3.
REQ-034 rst_n asserted between releases of bits 1 and 2, clock stopped -> rst_out=3'b111 and ready 0 immediately; after release, rst_out[0] falls at edge 20 again.
